// File: rtl/param_ram.sv
// param_ram: parametrised single-clock RAM with handshaked read/write ports, byte enables, selectable read latency and range exceptions
//   clk, rst            : clock, asynchronous active-high reset
//   r_addr, read        : read word address and request (held until rrdy)
//   r_line, rrdy        : read data and one-cycle read-done pulse
//   w_addr, w_line, w_be: write word address, data and byte enables
//   write, wrdy         : write request (held until wrdy) and one-cycle write-done pulse
//   exc, exc_code       : one-cycle exception pulse; bit0 read out of range, bit1 write out of range
module param_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 1024,
  parameter int RD_LAT = 1,
  parameter bit WRITE_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   r_addr,
  input  logic                read,
  output logic [DATA_W-1:0]   r_line,
  output logic                rrdy,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_line,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic                write,
  output logic                wrdy,
  output logic                exc,
  output logic [1:0]          exc_code
);
  localparam int NB = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DONE} r_state_t;
  typedef enum logic {W_IDLE, W_DONE} w_state_t;
  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] bit_mask, w_merged, src, hold, r_data;
  logic [IW-1:0] r_idx, w_idx, cap, tgt;
  logic r_in, w_in, r_acc, w_acc, r_oor, w_oor, hit, r_fire;
  // Full-width compare so no high address bit can alias into the array.
  assign r_in = 64'(r_addr) < 64'(DEPTH);
  assign w_in = 64'(w_addr) < 64'(DEPTH);
  assign r_idx = IW'(r_addr);
  assign w_idx = IW'(w_addr);
  // rst gates the accepts so a write coinciding with reset never lands in memory.
  assign r_acc = !rst && r_state == R_IDLE && read && r_in;
  assign w_acc = !rst && w_state == W_IDLE && write && w_in;
  assign r_oor = r_state == R_IDLE && read && !r_in;
  assign w_oor = w_state == W_IDLE && write && !w_in;
  assign r_fire = (r_acc && RD_LAT == 1) || r_state == R_WAIT;
  // Accept edge follows the collision mode; a write landing while the read waits
  // is always folded into the held word so the pending read sees it.
  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < NB; i++) bit_mask[8*i +: 8] = {8{w_be[i]}};
    src = r_state == R_WAIT ? hold : mem[r_idx];
    tgt = r_state == R_WAIT ? cap : r_idx;
    hit = w_acc && w_idx == tgt && (r_state == R_WAIT || WRITE_FIRST);
    r_data = hit ? (src & ~bit_mask) | (w_line & bit_mask) : src;
    w_merged = (mem[w_idx] & ~bit_mask) | (w_line & bit_mask);
  end
  always_comb begin
    r_next = r_state == R_IDLE ? (r_acc ? (RD_LAT == 1 ? R_DONE : R_WAIT) : R_IDLE)
           : r_state == R_WAIT ? R_DONE : R_IDLE;
    w_next = w_acc ? W_DONE : W_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      r_line <= '0;
      rrdy <= 1'b0;
      wrdy <= 1'b0;
      exc <= 1'b0;
      exc_code <= '0;
      cap <= '0;
      hold <= '0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      rrdy <= r_fire;
      wrdy <= w_acc;
      exc <= r_oor || w_oor;
      exc_code <= {w_oor, r_oor};
      if (r_acc) begin
        cap <= r_idx;
        hold <= r_data;
      end
      if (r_fire) r_line <= r_data;
      else if (r_oor) r_line <= '0;
    end
  always_ff @(posedge clk)
    if (w_acc) mem[w_idx] <= w_merged;
endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: scoreboard bench for param_ram; instance 0 is RD_LAT=1/read-first, instance 1 is RD_LAT=2/write-first
module tb_param_ram;
  typedef struct {
    logic [31:0] d;
    int          c;
  } rexp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] r_addr [2], w_addr [2], w_line [2], r_line [2];
  logic [3:0]  w_be [2];
  logic [1:0]  exc_code [2];
  logic        read [2], write [2], rrdy [2], wrdy [2], exc [2];
  rexp_t       rq[$];
  logic [31:0] wq[$];
  logic [1:0]  eq[$];
  int cur = 0, cyc = 0, vec = 0, miss = 0, zreq = 0, zseen = 0;
  logic fin = 1'b0;
  param_ram #(.RD_LAT(1), .WRITE_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .r_addr(r_addr[0]), .read(read[0]), .r_line(r_line[0]), .rrdy(rrdy[0]),
    .w_addr(w_addr[0]), .w_line(w_line[0]), .w_be(w_be[0]), .write(write[0]), .wrdy(wrdy[0]),
    .exc(exc[0]), .exc_code(exc_code[0])
  );
  param_ram #(.RD_LAT(2), .WRITE_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .r_addr(r_addr[1]), .read(read[1]), .r_line(r_line[1]), .rrdy(rrdy[1]),
    .w_addr(w_addr[1]), .w_line(w_line[1]), .w_be(w_be[1]), .write(write[1]), .wrdy(wrdy[1]),
    .exc(exc[1]), .exc_code(exc_code[1])
  );
  // Monitor: owns the counters, pops the scoreboard whenever the active DUT presents a response.
  always @(negedge clk) begin
    rexp_t e;
    logic [1:0] ec;
    cyc++;
    if (zreq != zseen) begin
      zseen = zreq;
      for (int k = 0; k < 2; k++) begin
        vec++;
        if (r_line[k] !== 32'h0 || rrdy[k] !== 1'b0 || wrdy[k] !== 1'b0 || exc[k] !== 1'b0 || exc_code[k] !== 2'b00) begin
          miss++;
          $display("FAIL reset_zero inst%0d: r_line=%h rrdy=%b wrdy=%b exc=%b code=%b, required all 0",
                   k, r_line[k], rrdy[k], wrdy[k], exc[k], exc_code[k]);
        end
      end
    end
    if (rrdy[cur] === 1'b1) begin
      vec++;
      if (rq.size() == 0) begin
        miss++;
        $display("FAIL rrdy_unexpected inst%0d: r_line=%h at cycle %0d, required no rrdy", cur, r_line[cur], cyc);
      end else begin
        e = rq.pop_front();
        if (r_line[cur] !== e.d || (e.c >= 0 && e.c != cyc)) begin
          miss++;
          $display("FAIL read_data inst%0d: r_line=%h cycle=%0d, required %h cycle=%0d", cur, r_line[cur], cyc, e.d, e.c);
        end
      end
    end
    if (wrdy[cur] === 1'b1) begin
      vec++;
      if (wq.size() == 0) begin
        miss++;
        $display("FAIL wrdy_unexpected inst%0d at cycle %0d, required no wrdy", cur, cyc);
      end else void'(wq.pop_front());
    end
    if (exc[cur] === 1'b1) begin
      vec++;
      if (eq.size() == 0) begin
        miss++;
        $display("FAIL exc_unexpected inst%0d: code=%b, required no exc", cur, exc_code[cur]);
      end else begin
        ec = eq.pop_front();
        if (exc_code[cur] !== ec) begin
          miss++;
          $display("FAIL exc_code inst%0d: code=%b, required %b", cur, exc_code[cur], ec);
        end
      end
      if (exc_code[cur][0] === 1'b1) begin
        vec++;
        if (r_line[cur] !== 32'h0) begin
          miss++;
          $display("FAIL exc_rline inst%0d: r_line=%h, required 00000000", cur, r_line[cur]);
        end
      end
    end
    if (fin) begin
      vec++;
      if (rq.size() + wq.size() + eq.size() != 0) begin
        miss++;
        $display("FAIL missing_responses: reads=%0d writes=%0d excs=%0d outstanding, required 0",
                 rq.size(), wq.size(), eq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
    end
  end
  task automatic op(input int k, input logic rd, input logic [31:0] ra, input logic [31:0] exp_d,
                    input logic wr, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] be);
    logic [1:0] ec;
    logic rp, wp;
    ec = {wr && wa >= 32'd1024, rd && ra >= 32'd1024};
    if (rd && !ec[0]) rq.push_back('{d: exp_d, c: -1});
    if (wr && !ec[1]) wq.push_back(wa);
    if (ec != 2'b00) eq.push_back(ec);
    @(negedge clk);
    #1;
    read[k] = rd;
    r_addr[k] = ra;
    write[k] = wr;
    w_addr[k] = wa;
    w_line[k] = wd;
    w_be[k] = be;
    rp = rd;
    wp = wr;
    for (int i = 0; i < 8 && (rp || wp); i++) begin
      @(negedge clk);
      #1;
      if (rp && (rrdy[k] || (exc[k] && exc_code[k][0]))) begin
        rp = 1'b0;
        read[k] = 1'b0;
      end
      if (wp && (wrdy[k] || (exc[k] && exc_code[k][1]))) begin
        wp = 1'b0;
        write[k] = 1'b0;
      end
    end
    read[k] = 1'b0;
    write[k] = 1'b0;
    if (rp || wp) $display("timeout on inst%0d, response left outstanding", k);
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c0;
    for (int k = 0; k < 2; k++) begin
      read[k] = 1'b0;
      write[k] = 1'b0;
      r_addr[k] = '0;
      w_addr[k] = '0;
      w_line[k] = '0;
      w_be[k] = '0;
    end
    #1 zreq++;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    cur = 0;
    op(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 4'hF);
    op(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 4'h0);
    op(0, 0, 0, 0, 1, 5, 32'h11223344, 4'b0101);
    op(0, 1, 5, 32'hDE22BE44, 0, 0, 0, 4'h0);
    op(0, 0, 0, 0, 1, 5, 32'hFFFFFFFF, 4'h0);
    op(0, 1, 5, 32'hDE22BE44, 0, 0, 0, 4'h0);
    op(0, 1, 1024, 0, 1, 1023, 32'h12345678, 4'hF);
    op(0, 1, 1023, 32'h12345678, 0, 0, 0, 4'h0);
    op(0, 1, 32'h80000005, 0, 0, 0, 0, 4'h0);
    op(0, 0, 0, 0, 1, 0, 32'h0BADF00D, 4'hF);
    op(0, 0, 0, 0, 1, 1024, 32'h0000CAFE, 4'hF);
    op(0, 1, 0, 32'h0BADF00D, 0, 0, 0, 4'h0);
    op(0, 1, 2000, 0, 1, 32'hFFFFFFFF, 32'h1, 4'hF);
    op(0, 0, 0, 0, 1, 7, 32'hAAAAAAAA, 4'hF);
    op(0, 1, 7, 32'hAAAAAAAA, 1, 7, 32'h55555555, 4'hF);
    op(0, 1, 7, 32'h55555555, 0, 0, 0, 4'h0);
    cur = 1;
    op(1, 0, 0, 0, 1, 7, 32'hAAAAAAAA, 4'hF);
    op(1, 1, 7, 32'h55555555, 1, 7, 32'h55555555, 4'hF);
    op(1, 1, 7, 32'h55555599, 1, 7, 32'h00000099, 4'b0001);
    op(1, 1, 7, 32'h55555599, 0, 0, 0, 4'h0);
    op(1, 0, 0, 0, 1, 3, 32'h00003333, 4'hF);
    // Read held for nine edges; the first accept edge is edge 1, rrdy on edges 2, 5, 8.
    @(negedge clk);
    #1 c0 = cyc;
    for (int i = 0; i < 3; i++) rq.push_back('{d: 32'h00003333, c: c0 + 2 + 3 * i});
    r_addr[1] = 3;
    read[1] = 1'b1;
    repeat (9) @(negedge clk);
    #1 read[1] = 1'b0;
    repeat (2) @(negedge clk);
    op(1, 1, 3, 32'h00003333, 0, 0, 0, 4'h0);
    // Reset while the RD_LAT=2 read sits in R_WAIT: outputs clear at once, no rrdy follows.
    @(negedge clk);
    #1 read[1] = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    read[1] = 1'b0;
    zreq++;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    op(1, 1, 3, 32'h00003333, 0, 0, 0, 4'h0);
    op(1, 1, 1024, 0, 1, 1023, 32'h00C0FFEE, 4'hF);
    op(1, 1, 1023, 32'h00C0FFEE, 0, 0, 0, 4'h0);
    repeat (2) @(negedge clk);
    #1 fin = 1'b1;
  end
endmodule

// File: doc/param_ram.md
Name: param_ram

Overview:
- Parametrised single-clock memory with independent read and write ports and a per-port ready handshake.
- Adds the following over the fixed 32-bit/1024-word RAM:
  - configurable width and depth
  - byte-enable writes
  - selectable read latency
  - defined read/write collision mode
  - asynchronous reset
  - per-port out-of-range exception codes
- Serves as instruction/data store behind the CPU32 memory stage.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 32, address width in bits (word addresses).
- DEPTH, 1024, number of words; valid addresses are 0..DEPTH-1.
- RD_LAT, 1, read latency in cycles from the accept edge to the rrdy edge; legal values are 1 or 2.
- WRITE_FIRST, 0, same-edge same-address collision: 1 returns the new data, 0 returns the old data.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- r_addr  input  ADDR_W  read word address.
- read  input  1  read request; held until rrdy.
- r_line  output  DATA_W  read data; valid while rrdy=1, otherwise holds its last value.
- rrdy  output  1  read done; one-cycle pulse.
- w_addr  input  ADDR_W  write word address.
- w_line  input  DATA_W  write data.
- w_be  input  DATA_W/8  byte enables; bit i covers w_line[8i+7:8i].
- write  input  1  write request; held until wrdy.
- wrdy  output  1  write done; one-cycle pulse.
- exc  output  1  exception; one-cycle pulse.
- exc_code  output  2  bit0 = read out of range, bit1 = write out of range; valid with exc.

Behaviour:
- Reset (async assert, sync release):
  - r_line=0, rrdy=0, wrdy=0, exc=0, exc_code=0; both FSMs go to IDLE.
  - Memory contents are not cleared.
  - A read or write in flight is aborted; no rdy pulse is issued afterwards, and an aborted write does not modify memory.
- Read FSM states: R_IDLE, R_WAIT, R_DONE.
  - R_IDLE, read=1, r_addr>=DEPTH: exc=1, exc_code[0]=1, r_line=0, no rrdy; FSM stays in R_IDLE.
  - R_IDLE, read=1, r_addr<DEPTH: address is captured at the accept edge and memory is sampled at that edge.
    - RD_LAT=1: r_line and rrdy=1 are registered at the accept edge; go to R_DONE.
    - RD_LAT=2: go to R_WAIT; the next edge registers r_line and rrdy=1, then go to R_DONE.
  - R_DONE: rrdy returns to 0 on the next edge; go to R_IDLE; read is not sampled at this edge (mandatory one-cycle turnaround).
  - Steady-state throughput with read held high: one read per RD_LAT+1 cycles.
- Write FSM states: W_IDLE, W_DONE.
  - W_IDLE, write=1, w_addr>=DEPTH: exc=1, exc_code[1]=1, no memory change, no wrdy.
  - W_IDLE, write=1, w_addr<DEPTH: only bytes with w_be[i]=1 are updated; wrdy=1 on the same edge; go to W_DONE.
  - w_be=0 is legal: no bytes change, but wrdy still pulses.
  - W_DONE: wrdy returns to 0 on the next edge; go to W_IDLE; write is ignored during this turnaround.
- Collision (read and write accepted on the same edge at the same in-range address):
  - WRITE_FIRST=0: read returns pre-write data.
  - WRITE_FIRST=1: read returns the merged post-write word, with byte enables applied.
  - For RD_LAT=2, a write landing on the captured address during R_WAIT is visible to the pending read.
- exc behaviour:
  - Both exc_code bits may assert together.
  - exc and exc_code are 0 on every edge with no out-of-range accept, so every exception is a single-cycle pulse.
  - An exception on one port does not disturb the other port.
- Width rules:
  - The full ADDR_W address is compared against DEPTH; no truncation or wrap-around.
  - Address DEPTH-1 is valid; address DEPTH raises an exception.

Test Plan:
- Reset, RD_LAT=1: write 0xDEADBEEF to addr 5 with w_be=4'hF → wrdy pulses for 1 cycle. Then read addr 5 → r_line=0xDEADBEEF with rrdy on the accept edge.
- Byte enables: addr 5 holds 0xDEADBEEF; write 0x11223344 with w_be=4'b0101 → a later read returns 0xDE22BE44. A write with w_be=0 leaves the word unchanged and wrdy still pulses.
- Range check: read addr 1024 → exc=1, exc_code=2'b01, r_line=0, no rrdy. In the same cycle, write addr 1023 → wrdy, and the data is stored.
- Collision: addr 7 holds 0xAAAAAAAA; same-edge write 0x55555555 and read of addr 7 → r_line=0xAAAAAAAA with WRITE_FIRST=0, 0x55555555 with WRITE_FIRST=1.
- RD_LAT=2 with read held high for 9 cycles → rrdy pulses at cycles 2, 5, 8 after the first accept, each for 1 cycle.
- Reset asserted while in R_WAIT (RD_LAT=2) → rrdy never pulses and all outputs read 0 immediately. After release, a new read completes normally.
